// File: rtl/quick_pq_pkg.sv
// ============================================================================
// quick_pq_pkg : shared state type, key-compare width and ordering function
// Revision     : 1.0
// ============================================================================
`default_nettype none

package quick_pq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    INSERT = 1'b1
  } pq_state_t;

  // Keys are zero-extended to this width before comparison (KW must be <= 64).
  localparam int c_KEY_W = 64;

  // Strict ordering so equal keys keep arrival order.
  function automatic logic better(
    input logic [c_KEY_W-1:0] a,
    input logic [c_KEY_W-1:0] b,
    input logic               max_first
  );
    return max_first ? (a > b) : (a < b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/quick_pq_stats.sv
// ============================================================================
// quick_pq_stats : peak occupancy and sticky overflow tracking
// Revision       : 1.0
// ============================================================================
`default_nettype none

module quick_pq_stats #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          insert_done,
  input  logic [CW-1:0] count_next,
  input  logic          overflow_evt,
  output logic [CW-1:0] peak_count,
  output logic          overflow_err
);

  logic [CW-1:0] r_peak;
  logic          r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_peak <= '0;
      r_ovf  <= 1'b0;
    end else if (flush) begin
      r_peak <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (insert_done && (count_next > r_peak)) r_peak <= count_next;
      if (overflow_evt) r_ovf <= 1'b1;
    end
  end

  assign peak_count   = r_peak;
  assign overflow_err = r_ovf;

endmodule

`default_nettype wire

// File: rtl/quick_pq_core.sv
// ============================================================================
// quick_pq_core : sorted priority queue, insertion-sort enqueue, 1-cycle dequeue
// Optional stats ports enabled by QUICK_PQ_STATS_EN.       Revision : 1.0
// ============================================================================
`default_nettype none

module quick_pq_core
  import quick_pq_pkg::*;
#(
  parameter int KW        = 16,
  parameter int DW        = 16,
  parameter int DEPTH     = 8,
  parameter int MAX_FIRST = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [KW-1:0] enq_key,
  input  logic [DW-1:0] enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [KW-1:0] deq_key,
  output logic [DW-1:0] deq_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy
`ifdef QUICK_PQ_STATS_EN
  ,
  output logic [CW-1:0] peak_count,
  output logic          overflow_err
`endif
);

  localparam int            c_PW        = $clog2(DEPTH);
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
  localparam logic          c_MAX_FIRST = (MAX_FIRST != 0);

  logic [KW-1:0]   r_mem_key  [DEPTH];
  logic [DW-1:0]   r_mem_data [DEPTH];
  logic [KW-1:0]   r_hold_key;
  logic [DW-1:0]   r_hold_data;
  logic [c_PW-1:0] r_ptr;
  logic [CW-1:0]   r_count;
  pq_state_t       r_state;

  pq_state_t       w_state_next;
  logic            w_enq_fire;
  logic            w_deq_fire;
  logic            w_shift;
  logic            w_insert_done;
  logic [CW-1:0]   w_count_after_deq;
  logic [c_PW-1:0] w_ptr_m1;

  assign full      = (r_count == c_DEPTH_CNT);
  assign empty     = (r_count == '0);
  assign busy      = (r_state == INSERT);
  assign enq_ready = (r_state == IDLE) && !full;
  assign deq_valid = (r_state == IDLE) && !empty;
  assign count     = r_count;
  assign deq_key   = r_mem_key[0];
  assign deq_data  = r_mem_data[0];

  assign w_enq_fire        = enq_valid && enq_ready;
  assign w_deq_fire        = deq_valid && deq_ready;
  assign w_count_after_deq = r_count - {{(CW-1){1'b0}}, w_deq_fire};
  assign w_ptr_m1          = r_ptr - {{(c_PW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The hole at r_ptr walks toward the head until the held key no longer wins.
  always_comb begin
    w_state_next  = r_state;
    w_shift       = 1'b0;
    w_insert_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enq_fire) w_state_next = INSERT;
      end
      INSERT: begin
        w_shift = (r_ptr != '0) &&
                  better(c_KEY_W'(r_hold_key), c_KEY_W'(r_mem_key[w_ptr_m1]), c_MAX_FIRST);
        if (!w_shift) begin
          w_insert_done = 1'b1;
          w_state_next  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_key[i]  <= '0;
        r_mem_data[i] <= '0;
      end
      r_hold_key  <= '0;
      r_hold_data <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (r_state == IDLE) begin
      // Dequeue shift first; a same-cycle insert starts from the shifted array.
      if (w_deq_fire) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r_mem_key[i]  <= r_mem_key[i+1];
          r_mem_data[i] <= r_mem_data[i+1];
        end
        r_mem_key[DEPTH-1]  <= '0;
        r_mem_data[DEPTH-1] <= '0;
        r_count             <= w_count_after_deq;
      end
      if (w_enq_fire) begin
        r_hold_key  <= enq_key;
        r_hold_data <= enq_data;
        r_ptr       <= w_count_after_deq[c_PW-1:0];
      end
    end else if (w_shift) begin
      r_mem_key[r_ptr]  <= r_mem_key[w_ptr_m1];
      r_mem_data[r_ptr] <= r_mem_data[w_ptr_m1];
      r_ptr             <= w_ptr_m1;
    end else begin
      r_mem_key[r_ptr]  <= r_hold_key;
      r_mem_data[r_ptr] <= r_hold_data;
      r_count           <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

`ifdef QUICK_PQ_STATS_EN
  quick_pq_stats #(
    .CW (CW)
  ) u_stats (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .insert_done  (w_insert_done),
    .count_next   (r_count + {{(CW-1){1'b0}}, 1'b1}),
    .overflow_evt (enq_valid && full && (r_state == IDLE)),
    .peak_count   (peak_count),
    .overflow_err (overflow_err)
  );
`endif

endmodule

`default_nettype wire

// File: doc/quick_pq_core.md
Name: quick_pq_core

Overview:
- Parametrised successor to the QuickQueue top: a sorted priority queue holding DEPTH {key, data} entries in a register array kept ordered, with the head at index 0.
- Enqueue uses one insertion-sort step per cycle, driven by a small FSM. Dequeue is a single-cycle parallel shift.
- Valid/ready handshakes replace the bare enq/deq strobes.
- The block sits between producer logic and the node chaining layer as the per-node queue engine.

Parameters:
- KW, 16, key width in bits.
- DW, 16, payload width in bits.
- DEPTH, 8, number of entries; must be >= 2.
- MAX_FIRST, 0. When 0, the smallest key is dequeued first. When 1, the largest key is dequeued first.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  synchronous clear.
- enq_valid  in  1  producer offers an entry.
- enq_ready  out  1  queue accepts an entry.
- enq_key  in  KW  key of the offered entry.
- enq_data  in  DW  payload of the offered entry.
- deq_valid  out  1  head entry is available.
- deq_ready  in  1  consumer takes the head.
- deq_key  out  KW  head key.
- deq_data  out  DW  head payload.
- count  out  CW = $clog2(DEPTH+1)  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- busy  out  1  state == INSERT.

Behaviour:
- Interface (decided): one clock, clk; rst is asynchronous, active-low.
- Reset values:
  - state = IDLE, count = 0.
  - All mem entries = 0, so deq_key = 0 and deq_data = 0.
  - enq_ready = 1, deq_valid = 0, full = 0, empty = 1, busy = 0.
- Output sources:
  - deq_key and deq_data are driven directly from mem[0], so they are registered.
  - enq_ready = (state == IDLE) && !full.
  - deq_valid = (state == IDLE) && !empty.
- better(a, b):
  - When MAX_FIRST = 0: a < b, unsigned.
  - When MAX_FIRST = 1: a > b, unsigned.
  - Strict comparison, so equal keys leave in arrival order (stable).
- IDLE, dequeue fire (deq_valid && deq_ready): mem[i] <= mem[i+1] for i < DEPTH-1; mem[DEPTH-1] <= 0; count decrements.
- IDLE, enqueue fire (enq_valid && enq_ready):
  - hold <= {enq_key, enq_data}.
  - ptr <= count after any same-cycle dequeue.
  - state -> INSERT.
- IDLE, both fire in the same cycle: both are legal. The dequeue shift happens first, and insertion then runs on the shifted array.
- INSERT, each cycle:
  - If ptr != 0 and better(hold.key, mem[ptr-1].key): mem[ptr] <= mem[ptr-1]; ptr decrements.
  - Otherwise: mem[ptr] <= hold; count increments; state -> IDLE.
- Insert latency: k+1 INSERT cycles after the accept edge, where k = number of stored entries that hold.key beats.
  - Worst case is DEPTH cycles (a DEPTH-1 entry shift plus the write).
  - The new head is visible on deq_key in the cycle after the return to IDLE.
- No dequeue during INSERT (deq_valid = 0), and no second enqueue (enq_ready = 0).
- full: enq_ready stays 0 even if deq_ready is high. The consumer must drain first.
- Boundaries:
  - Dequeue when empty cannot fire.
  - ptr never exceeds DEPTH-1, because accept requires !full.
  - count is never wrapped.
- flush:
  - Highest synchronous priority.
  - count <= 0 and state <= IDLE; any in-flight insert aborts and hold is dropped.
  - mem contents are don't-care, but deq_valid = 0.
- rst asserted mid-INSERT: immediate return to the reset state. No partial entry survives.

Optional Feature:
- Macro: QUICK_PQ_STATS_EN.
- When defined, two extra outputs exist:
  - peak_count (CW): the maximum count since reset or flush, updated on insert completion.
  - overflow_err (1): sticky; set when enq_valid && full in IDLE; cleared only by rst or flush.
- When undefined, the ports and logic are absent and core behaviour is identical.

Decomposition:
- Package quick_pq_pkg holds:
  - typedef enum logic {IDLE, INSERT} pq_state_t.
  - A parametrised entry struct helper, or KW/DW-sized concatenation constants.
  - Function better(a, b, max_first).
- Sub-module quick_pq_stats: peak and overflow tracking, instantiated only under QUICK_PQ_STATS_EN.
- The storage array and FSM stay in quick_pq_core.

Test Plan:
- Reset:
  - Stimulus: assert rst low with enq/deq idle.
  - Response: count = 0, empty = 1, enq_ready = 1, deq_valid = 0, deq_key = 0.
- Sorted order (MAX_FIRST = 0, DEPTH = 8):
  - Stimulus: enqueue keys 5, 2, 9, 2 (data 0xA, 0xB, 0xC, 0xD).
  - Response: dequeues give key/data (2, 0xB), (2, 0xD), (5, 0xA), (9, 0xC); count reaches 4 and then 0.
- Insert latency:
  - Stimulus: with 7, 8, 9 stored, enqueue 1.
  - Response: busy for 4 cycles; enq_ready returns high on the 4th edge after accept; deq_key = 1 on the next cycle.
- Full:
  - Stimulus: 8 enqueues, then enq_valid = 1.
  - Response: full = 1 and enq_ready = 0. After one dequeue, enq_ready = 1. With STATS_EN, overflow_err = 1 and peak_count = 8.
- Simultaneous fire:
  - Stimulus: in IDLE with head 3 and entries {3, 6}, enqueue 4 while dequeuing.
  - Response: output 3; the array becomes {4, 6}; count stays 2.
- Flush mid-insert:
  - Stimulus: assert flush during INSERT.
  - Response: next cycle state = IDLE, count = 0, deq_valid = 0, and the held entry is never dequeued.
